cva5_flushable_fifo: RTL and testbench

CVA5_FLUSHABLE_FIFO -- requirements
Module: cva5_flushable_fifo

---
 rtl/cva5_flushable_fifo_pkg.sv | 12 +
 rtl/cva5_flushable_fifo_if.sv | 32 +++
 rtl/cva5_flushable_fifo_lutram.sv | 21 ++
 rtl/cva5_flushable_fifo.sv | 90 +++++++++
 tb/tb_cva5_flushable_fifo.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cva5_flushable_fifo_pkg.sv
// Shared sizing defaults and helpers for the flushable FIFO slice.
package cva5_flushable_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_DEPTH      = 6;

  // Pointer width for a ring of `depth` slots; never narrower than one bit.
  function automatic int ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/cva5_flushable_fifo_if.sv
// Push/pop/flush request bundle and FIFO status outputs.
interface cva5_flushable_fifo_if
  import cva5_flushable_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH
);
  logic                         push;
  logic                         pop;
  logic                         flush;
  logic [DATA_WIDTH-1:0]        data_in;
  logic [DATA_WIDTH-1:0]        data_out;
  logic                         valid;
  logic                         full;
  logic                         almost_full;
  logic                         almost_empty;
  logic [$clog2(DEPTH+1)-1:0]   count;
  logic                         overflow_err;
  logic                         underflow_err;

  modport master (
    output push, pop, flush, data_in,
    input  data_out, valid, full, almost_full, almost_empty, count,
           overflow_err, underflow_err
  );

  modport slave (
    input  push, pop, flush, data_in,
    output data_out, valid, full, almost_full, almost_empty, count,
           overflow_err, underflow_err
  );
endinterface

// File: rtl/cva5_flushable_fifo_lutram.sv
// One-write, one-async-read distributed RAM; contents are never reset.
module lutram_1w_1r #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 6,
  parameter int ADDR_W = (DEPTH <= 2) ? 1 : $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/cva5_flushable_fifo.sv
// First-word fall-through FIFO of exact DEPTH with flush, almost-flags and
// sticky overflow/underflow error flags.
module cva5_flushable_fifo
  import cva5_flushable_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int AF_LEVEL   = DEPTH - 1,
  parameter int AE_LEVEL   = 1
) (
  input logic                  clk,
  input logic                  rst,
  cva5_flushable_fifo_if.slave fifo
);
  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_LEVEL);

  if (DEPTH < 2) begin : g_bad_depth
    $error("cva5_flushable_fifo: DEPTH must be at least 2");
  end
  if (AF_LEVEL > DEPTH) begin : g_bad_af
    $error("cva5_flushable_fifo: AF_LEVEL must not exceed DEPTH");
  end
  if (AE_LEVEL >= DEPTH) begin : g_bad_ae
    $error("cva5_flushable_fifo: AE_LEVEL must be below DEPTH");
  end

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_valid;
  logic             w_full;
  logic             w_push_acc;
  logic             w_pop_acc;
  logic [PTR_W-1:0] w_wr_next;
  logic [PTR_W-1:0] w_rd_next;

  assign w_valid    = (r_count != '0);
  assign w_full     = (r_count == FULL_CNT);
  // A pop on empty is never bypassed to a same-cycle push.
  assign w_pop_acc  = fifo.pop & ~fifo.flush & w_valid;
  assign w_push_acc = fifo.push & ~fifo.flush & (~w_full | w_pop_acc);

  assign w_wr_next = (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
  assign w_rd_next = (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst || fifo.flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push_acc) r_wr_ptr <= w_wr_next;
      if (w_pop_acc)  r_rd_ptr <= w_rd_next;
      r_count <= r_count + CNT_W'(w_push_acc) - CNT_W'(w_pop_acc);
      if (fifo.push && !w_push_acc) r_overflow  <= 1'b1;
      if (fifo.pop && !w_pop_acc)   r_underflow <= 1'b1;
    end
  end

  lutram_1w_1r #(
    .WIDTH  (DATA_WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_push_acc),
    .i_waddr (r_wr_ptr),
    .i_wdata (fifo.data_in),
    .i_raddr (r_rd_ptr),
    .o_rdata (fifo.data_out)
  );

  assign fifo.valid         = w_valid;
  assign fifo.full          = w_full;
  assign fifo.almost_full   = (r_count >= AF_CNT);
  assign fifo.almost_empty  = (r_count <= AE_CNT);
  assign fifo.count         = r_count;
  assign fifo.overflow_err  = r_overflow;
  assign fifo.underflow_err = r_underflow;
endmodule

// File: tb/tb_cva5_flushable_fifo.sv
// Scoreboard bench for cva5_flushable_fifo at DEPTH=6, AF_LEVEL=5, AE_LEVEL=1.
module tb_cva5_flushable_fifo;
  localparam int DW    = 32;
  localparam int DEPTH = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests_run    = 0;
  int   tests_failed = 0;

  logic [DW-1:0] sb[$];
  bit            m_ovf = 1'b0;
  bit            m_unf = 1'b0;

  cva5_flushable_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) fifo_if ();

  cva5_flushable_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AF_LEVEL   (5),
    .AE_LEVEL   (1)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .fifo (fifo_if)
  );

  always #5 clk = ~clk;

  // One clock of stimulus; accepted pops are checked against the scoreboard head.
  task automatic step(input bit p, input bit o, input bit f, input logic [DW-1:0] d);
    bit            pa, wa;
    logic [DW-1:0] exp;
    fifo_if.push = p; fifo_if.pop = o; fifo_if.flush = f; fifo_if.data_in = d;
    #1;
    pa = o && !f && (sb.size() > 0);
    wa = p && !f && ((sb.size() < DEPTH) || pa);
    if (pa) begin
      exp = sb.pop_front();
      tests_run++;
      if (fifo_if.data_out !== exp) begin
        tests_failed++;
        $display("FAIL pop_data: got %h expected %h", fifo_if.data_out, exp);
      end
    end
    if (f) begin
      sb.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      if (p && !wa) m_ovf = 1'b1;
      if (o && !pa) m_unf = 1'b1;
      if (wa) sb.push_back(d);
    end
    @(posedge clk); #1;
    fifo_if.push = 1'b0; fifo_if.pop = 1'b0; fifo_if.flush = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0; fifo_if.push = 1'b1; fifo_if.pop = 1'b0; fifo_if.flush = 1'b0;
    fifo_if.data_in = 32'h99;
    @(posedge clk); #1;
    rst = 1'b1; fifo_if.push = 1'b0;
    sb.delete(); m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (fifo_if.count !== 3'd0 || fifo_if.valid !== 1'b0 || fifo_if.full !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: count=%0d valid=%b full=%b expected 0/0/0",
               fifo_if.count, fifo_if.valid, fifo_if.full);
    end
    tests_run++;
    if (fifo_if.almost_full !== 1'b0 || fifo_if.almost_empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_almost: af=%b ae=%b expected 0/1", fifo_if.almost_full, fifo_if.almost_empty);
    end
    tests_run++;
    if (fifo_if.overflow_err !== 1'b0 || fifo_if.underflow_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: ovf=%b unf=%b expected 0/0", fifo_if.overflow_err, fifo_if.underflow_err);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 0, 0, 32'h11 + i);
      tests_run++;
      if (int'(fifo_if.count) !== i + 1 || fifo_if.almost_full !== (i + 1 >= 5)
          || fifo_if.almost_empty !== (i + 1 <= 1)) begin
        tests_failed++;
        $display("FAIL fill_level: count=%0d af=%b ae=%b expected %0d/%b/%b", fifo_if.count,
                 fifo_if.almost_full, fifo_if.almost_empty, i + 1, (i + 1 >= 5), (i + 1 <= 1));
      end
    end
    tests_run++;
    if (fifo_if.full !== 1'b1) begin
      tests_failed++;
      $display("FAIL fill_full: got %b expected 1", fifo_if.full);
    end
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, '0);
    tests_run++;
    if (fifo_if.valid !== 1'b0 || fifo_if.count !== 3'd0 || fifo_if.underflow_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL drain_empty: valid=%b count=%0d unf=%b expected 0/0/0",
               fifo_if.valid, fifo_if.count, fifo_if.underflow_err);
    end
  endtask

  task automatic test_overflow();
    step(0, 0, 1, '0);
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 32'h21 + i);
    step(1, 0, 0, 32'hAA);
    tests_run++;
    if (fifo_if.overflow_err !== 1'b1 || fifo_if.count !== 3'd6 || fifo_if.full !== 1'b1) begin
      tests_failed++;
      $display("FAIL overflow_reject: ovf=%b count=%0d full=%b expected 1/6/1",
               fifo_if.overflow_err, fifo_if.count, fifo_if.full);
    end
    step(1, 1, 0, 32'hAA);
    tests_run++;
    if (fifo_if.count !== 3'd6 || fifo_if.overflow_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_push_pop: count=%0d ovf=%b expected 6/1", fifo_if.count, fifo_if.overflow_err);
    end
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, '0);
    tests_run++;
    if (fifo_if.valid !== 1'b0 || fifo_if.overflow_err !== m_ovf) begin
      tests_failed++;
      $display("FAIL overflow_sticky: valid=%b ovf=%b expected 0/%b", fifo_if.valid, fifo_if.overflow_err, m_ovf);
    end
  endtask

  task automatic test_underflow();
    step(0, 0, 1, '0);
    step(1, 1, 0, 32'h5);
    tests_run++;
    if (fifo_if.count !== 3'd1 || fifo_if.valid !== 1'b1 || fifo_if.data_out !== 32'h5) begin
      tests_failed++;
      $display("FAIL empty_push_pop: count=%0d valid=%b data=%h expected 1/1/00000005",
               fifo_if.count, fifo_if.valid, fifo_if.data_out);
    end
    tests_run++;
    if (fifo_if.underflow_err !== 1'b1 || fifo_if.overflow_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL underflow_flag: unf=%b ovf=%b expected 1/0", fifo_if.underflow_err, fifo_if.overflow_err);
    end
    step(0, 1, 0, '0);
    tests_run++;
    if (fifo_if.underflow_err !== m_unf || fifo_if.valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL underflow_sticky: unf=%b valid=%b expected %b/0", fifo_if.underflow_err, fifo_if.valid, m_unf);
    end
  endtask

  task automatic test_wrap();
    int bad = 0;
    step(0, 0, 1, '0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 32'h40 + i);
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 0, 32'h50 + i);
      if (int'(fifo_if.count) !== 3) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL wrap_count: %0d cycles had count %0d expected 3", bad, fifo_if.count);
    end
    for (int i = 0; i < 3; i++) step(0, 1, 0, '0);
    tests_run++;
    if (fifo_if.valid !== 1'b0 || sb.size() != 0) begin
      tests_failed++;
      $display("FAIL wrap_drain: valid=%b expected 0", fifo_if.valid);
    end
  endtask

  task automatic test_flush();
    step(0, 0, 1, '0);
    step(0, 1, 0, '0);
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 32'h30 + i);
    step(1, 0, 0, 32'hBB);
    step(0, 1, 0, '0);
    step(0, 1, 0, '0);
    tests_run++;
    if (fifo_if.count !== 3'd4 || fifo_if.overflow_err !== 1'b1 || fifo_if.underflow_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_setup: count=%0d ovf=%b unf=%b expected 4/1/1",
               fifo_if.count, fifo_if.overflow_err, fifo_if.underflow_err);
    end
    step(1, 1, 1, 32'hEE);
    tests_run++;
    if (fifo_if.count !== 3'd0 || fifo_if.valid !== 1'b0 || fifo_if.overflow_err !== 1'b0
        || fifo_if.underflow_err !== 1'b0 || fifo_if.almost_empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_clear: count=%0d valid=%b ovf=%b unf=%b ae=%b expected 0/0/0/0/1", fifo_if.count,
               fifo_if.valid, fifo_if.overflow_err, fifo_if.underflow_err, fifo_if.almost_empty);
    end
    step(1, 0, 0, 32'h61);
    tests_run++;
    if (fifo_if.data_out !== 32'h61 || fifo_if.count !== 3'd1) begin
      tests_failed++;
      $display("FAIL flush_refill: data=%h count=%0d expected 00000061/1", fifo_if.data_out, fifo_if.count);
    end
    step(1, 0, 0, 32'h62);
    step(0, 1, 0, '0);
    step(0, 1, 0, '0);
  endtask

  task automatic test_reset_mid();
    step(0, 0, 1, '0);
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 32'h70 + i);
    step(1, 0, 0, 32'hCC);
    step(0, 1, 0, '0);
    step(0, 1, 0, '0);
    do_reset();
    tests_run++;
    if (fifo_if.count !== 3'd0 || fifo_if.almost_empty !== 1'b1 || fifo_if.valid !== 1'b0
        || fifo_if.overflow_err !== 1'b0 || fifo_if.underflow_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid: count=%0d ae=%b valid=%b ovf=%b unf=%b expected 0/1/0/0/0", fifo_if.count,
               fifo_if.almost_empty, fifo_if.valid, fifo_if.overflow_err, fifo_if.underflow_err);
    end
    step(1, 0, 0, 32'h77);
    tests_run++;
    if (fifo_if.valid !== 1'b1 || fifo_if.data_out !== 32'h77 || fifo_if.count !== 3'd1) begin
      tests_failed++;
      $display("FAIL reset_refill: valid=%b data=%h count=%0d expected 1/00000077/1",
               fifo_if.valid, fifo_if.data_out, fifo_if.count);
    end
    step(0, 1, 0, '0);
  endtask

  initial begin
    fifo_if.push = 1'b0; fifo_if.pop = 1'b0; fifo_if.flush = 1'b0; fifo_if.data_in = '0;
    #2;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_wrap();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
